// File: rtl/fpu_add_sequencer.sv
// fpu_add_sequencer: register front end for the pipelined FP16 adder.
// Holds operands, issues one add at a time, waits for the completion
// pulse with a timeout, captures and classifies the result, counts
// completions and optionally chains the result back into operand A.
module fpu_add_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  addr,
   input  logic [31:0] data_in,
   input  logic        data_write,
   input  logic        data_read,
   output logic [31:0] data_out,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   output logic        add_valid_in,
   input  logic [31:0] add_result,
   input  logic        add_valid_out,
   output logic        irq
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [3:0] ADDR_OPA    = 4'h0;
   localparam logic [3:0] ADDR_OPB    = 4'h1;
   localparam logic [3:0] ADDR_CTRL   = 4'h2;
   localparam logic [3:0] ADDR_RESULT = 4'h3;
   localparam logic [3:0] ADDR_STATUS = 4'h4;
   localparam logic [3:0] ADDR_COUNT  = 4'h5;

   // Last value of the wait counter before the outstanding add is abandoned.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [15:0] opa;
   logic [15:0] opb;
   logic [15:0] res;
   logic [15:0] count;
   logic        acc;
   logic        irq_en;
   logic        done;
   logic        timeout;
   logic        f_nan;
   logic        f_inf;
   logic        f_zero;
   logic        f_sign;

   logic        idle;
   logic        busy;
   logic        wr_opa;
   logic        wr_opb;
   logic        wr_ctrl;
   logic        ctrl_start;
   logic        ctrl_clear;
   logic        rd_result;
   logic        capture;
   logic        expire;
   logic [15:0] cap;
   logic [4:0]  cap_exp;
   logic [9:0]  cap_frac;
   logic        cap_nan;
   logic        cap_inf;
   logic        cap_zero;
   logic        cap_sign;
   logic        unused_bits;

   // Host access decode and completion/timeout qualifiers.
   always_comb begin
      idle       = (state == IDLE);
      busy       = ~idle;
      wr_opa     = data_write & (addr == ADDR_OPA);
      wr_opb     = data_write & (addr == ADDR_OPB);
      wr_ctrl    = data_write & (addr == ADDR_CTRL);
      ctrl_clear = wr_ctrl & data_in[2];
      ctrl_start = wr_ctrl & data_in[0] & ~data_in[2];
      rd_result  = data_read & (addr == ADDR_RESULT);
      // A clear landing on the completion cycle aborts; the response is dropped.
      capture    = (state == WAIT) & add_valid_out & ~ctrl_clear;
      expire     = (state == WAIT) & ~add_valid_out & (wait_cnt == WAIT_LAST);
   end

   // FP16 classification of the incoming adder result.
   always_comb begin
      cap      = add_result[15:0];
      cap_exp  = cap[14:10];
      cap_frac = cap[9:0];
      cap_nan  = (cap_exp == 5'h1F) & (cap_frac != 10'd0);
      cap_inf  = (cap_exp == 5'h1F) & (cap_frac == 10'd0);
      cap_zero = (cap[14:0] == 15'd0);
      cap_sign = cap[15];
   end

   // Operand registers and latched control bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa    <= '0;
         opb    <= '0;
         acc    <= 1'b0;
         irq_en <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            acc    <= data_in[1];
            irq_en <= data_in[3];
         end
         if (idle && wr_opa)
            opa <= data_in[15:0];
         else if (capture && acc)
            opa <= cap;
         if (idle && wr_opb)
            opb <= data_in[15:0];
      end
   end

   // Issue/wait sequencer with result capture, status and completion count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         add_valid_in <= 1'b0;
         wait_cnt     <= '0;
         res          <= '0;
         count        <= '0;
         done         <= 1'b0;
         timeout      <= 1'b0;
         f_nan        <= 1'b0;
         f_inf        <= 1'b0;
         f_zero       <= 1'b0;
         f_sign       <= 1'b0;
      end else if (ctrl_clear) begin
         state        <= IDLE;
         add_valid_in <= 1'b0;
         wait_cnt     <= '0;
         res          <= '0;
         count        <= '0;
         done         <= 1'b0;
         timeout      <= 1'b0;
         f_nan        <= 1'b0;
         f_inf        <= 1'b0;
         f_zero       <= 1'b0;
         f_sign       <= 1'b0;
      end else begin
         add_valid_in <= 1'b0;
         // Reading RESULT acknowledges done; a same-edge capture overrides below.
         if (rd_result)
            done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ctrl_start) begin
                  state        <= ISSUE;
                  add_valid_in <= 1'b1;
                  done         <= 1'b0;
                  timeout      <= 1'b0;
               end
            end
            ISSUE: begin
               state    <= WAIT;
               wait_cnt <= '0;
            end
            WAIT: begin
               if (capture) begin
                  res    <= cap;
                  f_nan  <= cap_nan;
                  f_inf  <= cap_inf;
                  f_zero <= cap_zero;
                  f_sign <= cap_sign;
                  done   <= 1'b1;
                  count  <= count + 16'd1;
                  state  <= IDLE;
               end else if (expire) begin
                  timeout <= 1'b1;
                  state   <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Combinational read mux; write-only and unmapped addresses read zero.
   always_comb begin
      data_out = '0;
      unique case (addr)
         ADDR_OPA:    data_out = {16'd0, opa};
         ADDR_OPB:    data_out = {16'd0, opb};
         ADDR_RESULT: data_out = {16'd0, res};
         ADDR_STATUS: data_out = {25'd0, timeout, f_sign, f_zero, f_inf, f_nan, done, busy};
         ADDR_COUNT:  data_out = {16'd0, count};
         default:     data_out = '0;
      endcase
   end

   assign add_a       = {16'd0, opa};
   assign add_b       = {16'd0, opb};
   assign irq         = done & irq_en;
   assign unused_bits = &{1'b0, add_result[31:16], data_in[31:16]};

endmodule

// File: tb/tb_fpu_add_sequencer.sv
// tb_fpu_add_sequencer: table-driven, hand-sequenced and randomized checks
// of the FP16 add sequencer against a register-level reference model, with
// a 6-stage behavioural adder providing the responses.
module tb_fpu_add_sequencer;

   logic        clk;
   logic        rst_n;
   logic [3:0]  addr;
   logic [31:0] data_in;
   logic        data_write;
   logic        data_read;
   logic [31:0] data_out;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_valid_in;
   logic [31:0] add_result;
   logic        add_valid_out;
   logic        irq;

   int checks = 0;
   int errors = 0;

   fpu_add_sequencer #(.TIMEOUT_CYCLES(15)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .addr          (addr),
      .data_in       (data_in),
      .data_write    (data_write),
      .data_read     (data_read),
      .data_out      (data_out),
      .add_a         (add_a),
      .add_b         (add_b),
      .add_valid_in  (add_valid_in),
      .add_result    (add_result),
      .add_valid_out (add_valid_out),
      .irq           (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- FP16 arithmetic via real numbers ----------------
   function automatic real p2(input int e);
      real r;
      r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real h2r(input logic [15:0] h);
      real v;
      int  e;
      int  m;
      e = int'(h[14:10]);
      m = int'(h[9:0]);
      if (e == 0) v = real'(m) * p2(-24);
      else        v = real'(1024 + m) * p2(e - 25);
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] r2h(input real r);
      logic s;
      real  a;
      int   e;
      int   f;
      s = (r < 0.0);
      a = s ? -r : r;
      if (a == 0.0) return {s, 15'd0};
      if (a < p2(-14)) begin
         f = $rtoi(a * p2(24) + 0.5);
         if (f >= 1024) return {s, 5'd1, 10'd0};
         return {s, 5'd0, f[9:0]};
      end
      e = 0;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      f = $rtoi((a - 1.0) * 1024.0 + 0.5);
      if (f == 1024) begin f = 0; e++; end
      if (e > 15) return {s, 15'h7C00};
      return {s, 5'(e + 15), f[9:0]};
   endfunction

   function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
      logic a_nan, b_nan, a_inf, b_inf;
      a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
      b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
      a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
      b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
      if (a_nan || b_nan) return 16'h7E00;
      if (a_inf && b_inf) return (a[15] != b[15]) ? 16'h7C01 : a;
      if (a_inf) return a;
      if (b_inf) return b;
      return r2h(h2r(a) + h2r(b));
   endfunction

   // {sign, zero, inf, nan}
   function automatic logic [3:0] flags_of(input logic [15:0] h);
      logic nan, inf, zero;
      nan  = (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
      inf  = (h[14:10] == 5'h1F) && (h[9:0] == 10'd0);
      zero = (h[14:0] == 15'd0);
      return {h[15], zero, inf, nan};
   endfunction

   // ---------------- behavioural 6-stage adder ----------------
   logic [5:0]  pv = '0;
   logic [15:0] pr [6];
   logic        mute = 1'b0;
   logic        inject = 1'b0;

   always @(posedge clk) begin
      pv    <= {pv[4:0], add_valid_in};
      pr[0] <= fp16_add(add_a[15:0], add_b[15:0]);
      for (int i = 1; i < 6; i++) pr[i] <= pr[i-1];
   end

   assign add_valid_out = (pv[5] & ~mute) | inject;
   assign add_result    = {16'hDEAD, pr[5]};

   // ---------------- reference model state ----------------
   logic [15:0] m_opa, m_opb, m_res, m_count;
   logic [3:0]  m_flags;
   logic        m_done, m_tmo, m_acc, m_irq_en;

   task automatic model_reset();
      m_opa = '0; m_opb = '0; m_res = '0; m_count = '0; m_flags = '0;
      m_done = 1'b0; m_tmo = 1'b0; m_acc = 1'b0; m_irq_en = 1'b0;
   endtask

   task automatic model_clear();
      m_res = '0; m_count = '0; m_flags = '0; m_done = 1'b0; m_tmo = 1'b0;
   endtask

   task automatic model_complete();
      logic [15:0] r;
      r       = fp16_add(m_opa, m_opb);
      m_res   = r;
      m_flags = flags_of(r);
      m_done  = 1'b1;
      m_count = m_count + 16'd1;
      if (m_acc) m_opa = r;
   endtask

   // ---------------- bus helpers and checks ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; data_in = d; data_write = 1'b1;
      @(negedge clk);
      data_write = 1'b0; addr = 4'h4;
      #1;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] v);
      addr = a;
      #1 v = data_out;
   endtask

   task automatic rd_result(input string tag);
      @(negedge clk);
      addr = 4'h3; data_read = 1'b1;
      #1 chk({tag, " read RESULT"}, data_out, {16'd0, m_res});
      @(negedge clk);
      data_read = 1'b0; addr = 4'h4;
      m_done = 1'b0;
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      logic [31:0] v;
      n = 0;
      rd(4'h4, v);
      while (v[0] && n < 60) begin
         @(negedge clk);
         rd(4'h4, v);
         n++;
      end
      if (n >= 60) begin
         checks++; errors++;
         $display("FAIL %s wait_idle: still busy after %0d cycles, required idle", tag, n);
      end
   endtask

   task automatic check_regs(input string tag);
      logic [31:0] v;
      rd(4'h3, v); chk({tag, " RESULT"}, v, {16'd0, m_res});
      rd(4'h4, v); chk({tag, " STATUS"}, v, {25'd0, m_tmo, m_flags, m_done, 1'b0});
      rd(4'h5, v); chk({tag, " COUNT"},  v, {16'd0, m_count});
      rd(4'h0, v); chk({tag, " OPA"},    v, {16'd0, m_opa});
      rd(4'h1, v); chk({tag, " OPB"},    v, {16'd0, m_opb});
      chk({tag, " irq"}, {31'd0, irq}, {31'd0, m_done & m_irq_en});
   endtask

   task automatic do_op(input bit wr_a, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] ctrl, input string tag);
      if (wr_a) begin
         wr(4'h0, {16'($urandom), a});
         m_opa = a;
      end
      wr(4'h1, {16'($urandom), b});
      m_opb = b;
      wr(4'h2, {28'd0, ctrl});
      m_acc = ctrl[1]; m_irq_en = ctrl[3]; m_done = 1'b0; m_tmo = 1'b0;
      wait_idle(tag);
      model_complete();
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [7:0]  status;
   } vec_t;

   vec_t vecs[5];
   logic [15:0] acc_exp[3];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      int          n;

      vecs[0] = '{a: 16'h3C00, b: 16'h3C00, res: 16'h4000, status: 8'h02};
      vecs[1] = '{a: 16'h7C00, b: 16'hFC00, res: 16'h7C01, status: 8'h06};
      vecs[2] = '{a: 16'h3C00, b: 16'hBC00, res: 16'h0000, status: 8'h12};
      vecs[3] = '{a: 16'hC000, b: 16'h3C00, res: 16'hBC00, status: 8'h22};
      vecs[4] = '{a: 16'h7C00, b: 16'h3C00, res: 16'h7C00, status: 8'h0A};
      acc_exp[0] = 16'h4000; acc_exp[1] = 16'h4200; acc_exp[2] = 16'h4400;

      rst_n = 1'b0; addr = '0; data_in = '0; data_write = 1'b0; data_read = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         rd(4'(i), v);
         chk($sformatf("reset data_out[%0d]", i), v, 32'd0);
      end
      chk("reset add_valid_in", {31'd0, add_valid_in}, 32'd0);
      chk("reset irq", {31'd0, irq}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic add with issue pulse and completion latency.
      wr(4'h0, 32'h0000_3C00); m_opa = 16'h3C00;
      wr(4'h1, 32'h0000_3C00); m_opb = 16'h3C00;
      wr(4'h2, 32'h1); m_acc = 1'b0; m_irq_en = 1'b0;
      chk("issue add_valid_in", {31'd0, add_valid_in}, 32'd1);
      chk("issue add_a", add_a, 32'h0000_3C00);
      chk("issue add_b", add_b, 32'h0000_3C00);
      n = 0;
      rd(4'h4, v);
      while (!v[1] && n < 40) begin
         @(negedge clk);
         rd(4'h4, v);
         n++;
         if (n == 1) chk("issue pulse single", {31'd0, add_valid_in}, 32'd0);
      end
      chk("done latency", n, 32'd7);
      model_complete();
      check_regs("basic");
      chk("basic RESULT const", {16'd0, m_res}, 32'h4000);
      rd_result("basic");
      check_regs("basic after read");
      rd(4'h2, v); chk("CTRL reads zero", v, 32'd0);
      wr(4'h9, 32'hFFFF_FFFF);
      rd(4'h9, v); chk("unmapped reads zero", v, 32'd0);
      check_regs("unmapped write");

      // Table of special/ordinary sums.
      for (int i = 0; i < 5; i++) begin
         do_op(1'b1, vecs[i].a, vecs[i].b, 4'h1, $sformatf("vec%0d", i));
         rd(4'h3, v); chk($sformatf("vec%0d RESULT", i), v, {16'd0, vecs[i].res});
         rd(4'h4, v); chk($sformatf("vec%0d STATUS", i), v, {24'd0, vecs[i].status});
         rd_result($sformatf("vec%0d", i));
         rd(4'h4, v); chk($sformatf("vec%0d STATUS read", i), v, {24'd0, vecs[i].status & 8'hFD});
      end

      // Accumulate chain.
      wr(4'h2, 32'h4); model_clear(); m_acc = 1'b0; m_irq_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         do_op(i == 0, 16'h3C00, 16'h3C00, 4'h3, $sformatf("acc%0d", i));
         rd(4'h3, v); chk($sformatf("acc%0d RESULT", i), v, {16'd0, acc_exp[i]});
      end
      rd(4'h0, v); chk("acc OPA", v, 32'h4400);
      rd(4'h5, v); chk("acc COUNT", v, 32'd3);
      check_regs("acc");

      // Randomized operations against the model.
      for (int i = 0; i < 24; i++) begin
         do_op(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
               {1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1}, $sformatf("rnd%0d", i));
         check_regs($sformatf("rnd%0d", i));
         if ($urandom_range(0, 1) == 1) rd_result($sformatf("rnd%0d", i));
      end

      // Timeout, then a stale response.
      mute = 1'b1;
      wr(4'h2, 32'h1); m_acc = 1'b0; m_irq_en = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
      n = 0;
      rd(4'h4, v);
      while (v[0] && n < 100) begin
         @(negedge clk);
         rd(4'h4, v);
         n++;
      end
      chk("timeout busy cycles", n, 32'd16);
      m_tmo = 1'b1;
      check_regs("timeout");
      @(negedge clk); inject = 1'b1;
      @(negedge clk); inject = 1'b0;
      #1 check_regs("late response");
      mute = 1'b0;

      // Busy protection: operand write and restart while outstanding.
      wr(4'h0, 32'h0000_4000); m_opa = 16'h4000;
      wr(4'h1, 32'h0000_3C00); m_opb = 16'h3C00;
      wr(4'h2, 32'h1); m_acc = 1'b0; m_irq_en = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
      wr(4'h0, 32'h0000_1234);
      wr(4'h2, 32'h1);
      wait_idle("busy");
      model_complete();
      check_regs("busy protect");
      repeat (10) @(negedge clk);
      #1 check_regs("busy no reissue");

      // Clear with start in idle.
      wr(4'h2, 32'h5); model_clear();
      chk("clr+start no issue", {31'd0, add_valid_in}, 32'd0);
      check_regs("clr+start");

      // Clear during WAIT aborts; the late response is dropped.
      wr(4'h2, 32'h1); m_done = 1'b0; m_tmo = 1'b0;
      repeat (3) @(negedge clk);
      wr(4'h2, 32'h4); model_clear();
      check_regs("clear in wait");
      repeat (10) @(negedge clk);
      #1 check_regs("clear late pulse");

      // RESULT read on the capture edge: capture wins.
      wr(4'h2, 32'h1); m_done = 1'b0; m_tmo = 1'b0;
      repeat (6) @(negedge clk);
      addr = 4'h3; data_read = 1'b1;
      @(negedge clk);
      data_read = 1'b0;
      model_complete();
      #1 check_regs("read vs capture");

      // Interrupt.
      wr(4'h2, 32'h9); m_irq_en = 1'b1; m_acc = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
      chk("irq low while busy", {31'd0, irq}, 32'd0);
      wait_idle("irq");
      model_complete();
      chk("irq high on done", {31'd0, irq}, 32'd1);
      check_regs("irq");
      rd_result("irq");
      chk("irq dropped by read", {31'd0, irq}, 32'd0);

      // Reset during WAIT.
      wr(4'h2, 32'h9); m_done = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst add_valid_in", {31'd0, add_valid_in}, 32'd0);
      chk("rst irq", {31'd0, irq}, 32'd0);
      chk("rst add_a", add_a, 32'd0);
      for (int i = 0; i < 6; i++) begin
         rd(4'(i), v);
         chk($sformatf("rst data_out[%0d]", i), v, 32'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (10) @(negedge clk);
      #1 check_regs("after reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
